s27_sig_analyzer: RTL and testbench
===================================

Name: s27_sig_analyzer

Overview:
- Downstream response compactor for the s27 benchmark core; consumes the G17 output stream.
- Serial-input signature register (SISR, Galois LFSR) with a run-control FSM.
- Flushes the core's 3-flop state after START, compacts a fixed number of valid G17 samples, then flags PASS/FAIL against an expected signature.
- Single-bit input and flag outputs, so it drops in as the on-chip BIST sink next to s27.

Parameters:
- SIG_W, 16: signature width in bits (at least 2).
- POLY, 16'h8005: feedback tap mask, Galois form, SIG_W bits wide.
- SEED, 16'h0000: signature value loaded at reset and on every START.
- SKIP, 3: flush cycles after START before capture begins. 0 is legal.
- COUNT, 256: number of valid samples to compact. Must be at least 1.
- EXPECT, 16'h0000: golden signature for the PASS compare.

Ports:
- CK  input  1  clock; all state updates on posedge.
- RN  input  1  synchronous active-low reset.
- START  input  1  run request pulse; honoured only in IDLE or DONE.
- G17  input  1  serial response bit from s27.
- VALID_IN  input  1  qualifies G17 as a sample during CAPTURE.
- SIG  output  SIG_W  current signature register.
- BUSY  output  1  high in SKIP or CAPTURE.
- DONE  output  1  high in DONE state.
- PASS  output  1  (SIG==EXPECT) while DONE; 0 otherwise.

Behaviour:
- Reset (RN=0 at posedge, any state, including mid-run):
  - state goes to IDLE, SIG=SEED, skip and sample counters cleared.
  - BUSY=0, DONE=0, PASS=0.
  - RN has priority over START.
- States: IDLE, SKIP, CAPTURE, DONE.
- IDLE:
  - START=1 loads SIG=SEED and clears both counters.
  - Next state is SKIP, or CAPTURE directly if SKIP==0.
- SKIP:
  - Skip counter increments every cycle, ignoring VALID_IN and G17.
  - After exactly SKIP cycles in SKIP, next state is CAPTURE.
- CAPTURE, on a cycle with VALID_IN=1:
  - fb = SIG[SIG_W-1] XOR G17.
  - SIG <= {SIG[SIG_W-2:0],0} XOR (fb ? POLY : 0).
  - Sample counter increments.
  - On the valid sample that makes the count equal COUNT, the update occurs in that same cycle and the next state is DONE.
- CAPTURE with VALID_IN=0: SIG and the counter hold.
- DONE:
  - SIG holds; DONE=1.
  - PASS is registered, set on the cycle DONE is entered, and stays stable.
  - START=1 restarts exactly as from IDLE: SIG=SEED, DONE=0, PASS=0 on the next cycle.
- START in SKIP or CAPTURE is ignored; there is no abort except reset.
- Latency: DONE and PASS rise on the cycle after the posedge that samples the final valid bit.
- Counters are sized ceil(log2(max(SKIP,COUNT)+1)) bits. No wrap within a run.
- BUSY = (state==SKIP)|(state==CAPTURE). It is registered-state decoded, so it is glitch-free.

Optional Feature:
- Macro: S27_SIG_RETIME_EN.
- Defined:
  - G17 and VALID_IN each pass through one input DFF before the SISR logic, matching the SFQ path balancing of the core.
  - The effective flush length becomes SKIP+1 so sample alignment to START is unchanged.
  - DONE/PASS rise one cycle later than without the macro.
- Undefined:
  - G17 and VALID_IN feed the SISR combinationally.
  - Flush length is SKIP.

Test Plan:
- Reset mid-CAPTURE:
  - Pull RN=0 for one cycle -> next cycle SIG=SEED, BUSY=0, DONE=0, PASS=0, state IDLE.
  - A following START runs normally.
- Single-one impulse (SEED=0, COUNT=1, SKIP=3):
  - START at cycle 0; BUSY=1 for cycles 1-3 of SKIP.
  - G17=1, VALID_IN=1 in the first CAPTURE cycle -> SIG=0x8005, DONE=1 next cycle.
  - With EXPECT=0x8005, PASS=1.
- Two-sample (SEED=0, COUNT=2, EXPECT=0):
  - Valid G17 sequence 1,0 -> SIG=0x8005 then 0x800F.
  - DONE=1, PASS=0.
- VALID_IN gaps (COUNT=2):
  - Valid bits 1,0 with VALID_IN=0 for 5 cycles between them -> SIG holds 0x8005 during the gap.
  - Final SIG=0x800F; DONE is delayed by exactly 5 cycles versus the no-gap case.
- All-zero stream (SEED=0, COUNT=256, EXPECT=0):
  - Result SIG=0x0000, PASS=1.
  - START pulses during SKIP/CAPTURE are ignored.
  - START in DONE -> DONE drops, SIG=0, a new run completes identically.
- With S27_SIG_RETIME_EN, repeat the single-one impulse -> identical SIG=0x8005, with DONE one cycle later than without the macro.

Source files
------------

// File: rtl/s27_sig_analyzer.sv
// s27_sig_analyzer: response compactor for the s27 benchmark core.
// A serial-input signature register (Galois LFSR) compacts a fixed number
// of valid G17 samples after a short flush window, then flags PASS when the
// final signature matches the golden value.
//
// Ports:
//   CK        in   clock, all state updates on posedge
//   RN        in   synchronous active-low reset (priority over START)
//   START     in   run request, honoured only in IDLE or DONE
//   G17       in   serial response bit from s27
//   VALID_IN  in   qualifies G17 as a sample during CAPTURE
//   SIG       out  current signature register (SIG_W bits)
//   BUSY      out  high while flushing or capturing
//   DONE      out  high in the DONE state
//   PASS      out  SIG==EXPECT, valid while DONE, 0 otherwise
//
// Build option: define S27_SIG_RETIME_EN to register G17/VALID_IN before
// the SISR. The flush window then grows by one cycle so sample alignment to
// START is unchanged, and DONE/PASS rise one cycle later.

module s27_sig_analyzer #(
    parameter int unsigned        SIG_W  = 16,
    parameter logic [SIG_W-1:0]   POLY   = 16'h8005,
    parameter logic [SIG_W-1:0]   SEED   = 16'h0000,
    parameter int unsigned        SKIP   = 3,
    parameter int unsigned        COUNT  = 256,
    parameter logic [SIG_W-1:0]   EXPECT = 16'h0000
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             START,
    input  logic             G17,
    input  logic             VALID_IN,
    output logic [SIG_W-1:0] SIG,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS
);

`ifdef S27_SIG_RETIME_EN
    localparam int unsigned SKIP_EFF = SKIP + 1;
`else
    localparam int unsigned SKIP_EFF = SKIP;
`endif

    localparam int unsigned CNT_MAX   = (SKIP_EFF > COUNT) ? SKIP_EFF : COUNT;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned SKIP_LAST = (SKIP_EFF == 0) ? 0 : SKIP_EFF - 1;
    localparam int unsigned CNT_LAST  = (COUNT == 0) ? 0 : COUNT - 1;

    localparam logic [CNT_W-1:0] SKIP_LAST_C = CNT_W'(SKIP_LAST);
    localparam logic [CNT_W-1:0] CNT_LAST_C  = CNT_W'(CNT_LAST);
    localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [CNT_W-1:0]   skip_cnt_q, skip_cnt_d;
    logic [CNT_W-1:0]   smp_cnt_q, smp_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic               smp_bit_c;
    logic               smp_vld_c;
    logic               fb_c;
    logic [SIG_W-1:0]   sig_step_c;

    // Sample path into the SISR: optionally balanced by one register stage.
`ifdef S27_SIG_RETIME_EN
    logic g17_q;
    logic valid_q;

    always_ff @(posedge CK) begin
        if (!RN) begin
            g17_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            g17_q   <= G17;
            valid_q <= VALID_IN;
        end
    end

    assign smp_bit_c = g17_q;
    assign smp_vld_c = valid_q;
`else
    assign smp_bit_c = G17;
    assign smp_vld_c = VALID_IN;
`endif

    // One Galois SISR step: shift left, fold the polynomial in on feedback.
    assign fb_c       = sig_q[SIG_W-1] ^ smp_bit_c;
    assign sig_step_c = {sig_q[SIG_W-2:0], 1'b0} ^ (fb_c ? POLY : '0);

    // State and datapath registers.
    always_ff @(posedge CK) begin
        if (!RN) begin
            state_q    <= ST_IDLE;
            sig_q      <= SEED;
            skip_cnt_q <= '0;
            smp_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sig_q      <= sig_d;
            skip_cnt_q <= skip_cnt_d;
            smp_cnt_q  <= smp_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    // Next-state, datapath and registered-flag logic.
    always_comb begin
        state_d    = state_q;
        sig_d      = sig_q;
        skip_cnt_d = skip_cnt_q;
        smp_cnt_d  = smp_cnt_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        pass_d     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    sig_d      = SEED;
                    skip_cnt_d = '0;
                    smp_cnt_d  = '0;
                    state_d    = (SKIP_EFF == 0) ? ST_CAPTURE : ST_SKIP;
                end
            end
            ST_SKIP: begin
                // Flush window: sample inputs are ignored entirely.
                skip_cnt_d = skip_cnt_q + CNT_ONE_C;
                if (skip_cnt_q == SKIP_LAST_C) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (smp_vld_c) begin
                    sig_d     = sig_step_c;
                    smp_cnt_d = smp_cnt_q + CNT_ONE_C;
                    if (smp_cnt_q == CNT_LAST_C) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flags track the state being entered, so they line up with it.
        busy_d = (state_d == ST_SKIP) || (state_d == ST_CAPTURE);
        done_d = (state_d == ST_DONE);
        if (state_d == ST_DONE) begin
            // Compare once on entry; hold the verdict while DONE lasts.
            pass_d = (state_q == ST_DONE) ? pass_q : (sig_d == EXPECT);
        end
    end

    assign SIG  = sig_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign PASS = pass_q;

endmodule

// File: tb/tb_s27_sig_analyzer.sv
// Bench for s27_sig_analyzer: three instances (COUNT 1/2/256) share clock
// and reset; expected SIG/DONE/PASS are queued when a sample is driven and
// checked on the cycle the design must show them.

module tb_s27_sig_analyzer;

`ifdef S27_SIG_RETIME_EN
    localparam int RT = 1;
`else
    localparam int RT = 0;
`endif
    localparam int NI = 3;

    logic        CK = 1'b0;
    logic        RN;
    logic        start [NI];
    logic        g17   [NI];
    logic        vin   [NI];
    logic [15:0] sig   [NI];
    logic        busy  [NI];
    logic        done  [NI];
    logic        pass  [NI];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    int          cnt_cfg [NI] = '{1, 2, 256};
    logic [15:0] exp_cfg [NI] = '{16'h8005, 16'h0000, 16'h0000};
    logic [15:0] msig    [NI];
    int          mcnt    [NI];

    typedef struct {
        int          due;
        int          inst;
        logic [15:0] sig;
        logic        done;
        logic        pass;
    } sb_t;
    sb_t sbq[$];

    always #5 CK = ~CK;

    s27_sig_analyzer #(.SIG_W(16), .POLY(16'h8005), .SEED(16'h0000), .SKIP(3),
                       .COUNT(1), .EXPECT(16'h8005)) u_imp (
        .CK(CK), .RN(RN), .START(start[0]), .G17(g17[0]), .VALID_IN(vin[0]),
        .SIG(sig[0]), .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]));

    s27_sig_analyzer #(.SIG_W(16), .POLY(16'h8005), .SEED(16'h0000), .SKIP(3),
                       .COUNT(2), .EXPECT(16'h0000)) u_two (
        .CK(CK), .RN(RN), .START(start[1]), .G17(g17[1]), .VALID_IN(vin[1]),
        .SIG(sig[1]), .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]));

    s27_sig_analyzer #(.SIG_W(16), .POLY(16'h8005), .SEED(16'h0000), .SKIP(3),
                       .COUNT(256), .EXPECT(16'h0000)) u_long (
        .CK(CK), .RN(RN), .START(start[2]), .G17(g17[2]), .VALID_IN(vin[2]),
        .SIG(sig[2]), .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]));

    task automatic chk(input string tag, input int inst, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, inst, got, exp);
        end
    endtask

    // Reference Galois step, x^16 + x^15 + x^2 + 1.
    function automatic logic [15:0] sisr(input logic [15:0] s, input logic b);
        logic [15:0] r;
        r = {s[14:0], 1'b0};
        if (s[15] ^ b) r = r ^ 16'h8005;
        return r;
    endfunction

    task automatic check_sb();
        sb_t e;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            chk("sb_sig",  e.inst, 32'(sig[e.inst]),  32'(e.sig));
            chk("sb_done", e.inst, 32'(done[e.inst]), 32'(e.done));
            chk("sb_pass", e.inst, 32'(pass[e.inst]), 32'(e.pass));
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
        cyc++;
        check_sb();
    endtask

    task automatic check_state(input int inst, input string tag, input logic [15:0] s,
                               input logic b, input logic d, input logic p);
        chk({tag, "_sig"},  inst, 32'(sig[inst]),  32'(s));
        chk({tag, "_busy"}, inst, 32'(busy[inst]), 32'(b));
        chk({tag, "_done"}, inst, 32'(done[inst]), 32'(d));
        chk({tag, "_pass"}, inst, 32'(pass[inst]), 32'(p));
    endtask

    // Drive one cycle of sample inputs; queue what the design must show.
    task automatic drive(input int inst, input logic v, input logic b, input logic st);
        sb_t  e;
        logic d;
        vin[inst]   = v;
        g17[inst]   = b;
        start[inst] = st;
        if (v) begin
            msig[inst] = sisr(msig[inst], b);
            mcnt[inst]++;
        end
        d      = (mcnt[inst] == cnt_cfg[inst]);
        e.due  = cyc + 1 + RT;
        e.inst = inst;
        e.sig  = msig[inst];
        e.done = d;
        e.pass = d && (msig[inst] == exp_cfg[inst]);
        sbq.push_back(e);
        tick();
        vin[inst]   = 1'b0;
        g17[inst]   = 1'b0;
        start[inst] = 1'b0;
    endtask

    task automatic drain();
        for (int r = 0; r < RT; r++) tick();
    endtask

    // START pulse, then the 3-cycle flush with noise on the sample inputs
    // and a stray START, all of which must be ignored.
    task automatic start_run(input int inst);
        start[inst] = 1'b1;
        msig[inst]  = 16'h0000;
        mcnt[inst]  = 0;
        tick();
        start[inst] = 1'b0;
        check_state(inst, "start", 16'h0000, 1'b1, 1'b0, 1'b0);
        vin[inst] = 1'b1;
        g17[inst] = 1'b1;
        tick();
        chk("skip_busy", inst, 32'(busy[inst]), 32'd1);
        start[inst] = 1'b1;
        tick();
        start[inst] = 1'b0;
        chk("skip_busy", inst, 32'(busy[inst]), 32'd1);
        tick();
        check_state(inst, "cap_entry", 16'h0000, 1'b1, 1'b0, 1'b0);
        vin[inst] = 1'b0;
        g17[inst] = 1'b0;
    endtask

    // mode 0: all-zero valid stream; mode 1: random bits with random gaps.
    task automatic feed(input int inst, input int mode);
        logic v;
        logic b;
        while (mcnt[inst] < cnt_cfg[inst]) begin
            v = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            b = (mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            drive(inst, v, b, (mcnt[inst] == 100) && v);
        end
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RN = 1'b0;
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0; g17[i] = 1'b0; vin[i] = 1'b0;
            msig[i] = 16'h0000; mcnt[i] = 0;
        end
        tick();
        tick();
        RN = 1'b1;
        for (int i = 0; i < NI; i++) check_state(i, "reset", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Single-one impulse, COUNT=1, golden 0x8005.
        start_run(0);
        drive(0, 1'b1, 1'b1, 1'b0);
        drain();
        check_state(0, "imp_done", 16'h8005, 1'b0, 1'b1, 1'b1);
        tick(); tick(); tick();
        check_state(0, "imp_hold", 16'h8005, 1'b0, 1'b1, 1'b1);

        // Two samples 1,0 with a 5-cycle VALID_IN gap (noisy G17, stray START).
        start_run(1);
        drive(1, 1'b1, 1'b1, 1'b0);
        for (int g = 0; g < 5; g++) drive(1, 1'b0, 1'($urandom_range(0, 1)), g == 2);
        drive(1, 1'b1, 1'b0, 1'b0);
        drain();
        check_state(1, "two_gap", 16'h800F, 1'b0, 1'b1, 1'b0);

        // Restart from DONE, same samples back to back.
        start_run(1);
        drive(1, 1'b1, 1'b1, 1'b0);
        drive(1, 1'b1, 1'b0, 1'b0);
        drain();
        check_state(1, "two_nogap", 16'h800F, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a capture.
        start_run(2);
        drive(2, 1'b1, 1'b1, 1'b0);
        drive(2, 1'b1, 1'b0, 1'b0);
        drive(2, 1'b1, 1'b1, 1'b0);
        drain();
        chk("mid_busy", 2, 32'(busy[2]), 32'd1);
        RN = 1'b0;
        start[2] = 1'b1;
        tick();
        RN = 1'b1;
        start[2] = 1'b0;
        for (int i = 0; i < NI; i++) check_state(i, "mid_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rst_idle_busy", 2, 32'(busy[2]), 32'd0);

        // All-zero 256-sample run, then an identical run restarted from DONE.
        start_run(2);
        feed(2, 0);
        check_state(2, "zero_done", 16'h0000, 1'b0, 1'b1, 1'b1);
        start_run(2);
        feed(2, 0);
        check_state(2, "zero_again", 16'h0000, 1'b0, 1'b1, 1'b1);

        // Random stream with gaps.
        start_run(2);
        feed(2, 1);
        check_state(2, "rand_done", msig[2], 1'b0, 1'b1, msig[2] == 16'h0000);

        chk("sb_left", 0, 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
